rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter_if.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - channel and output handshake bundle for rr_mux_arbiter
//
// Parameters: WIDTH (data width), N (channel count); SEL_W is derived.
// Signals:
//   in_data   [N*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid  [N]        channel i presents data
//   in_ready  [N]        channel i transfers this cycle (one-hot or zero)
//   out_data  [WIDTH]    registered winning data
//   out_sel   [SEL_W]    index of the channel that produced out_data
//   out_valid            out_data/out_sel hold an untaken beat
//   out_ready            downstream accepts the beat
// Modports: slave = arbiter side, master = surrounding logic side.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N:1 round-robin arbitrating mux with one registered output stage
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    rr_mux_arbiter_if.slave (N request channels in, one registered beat out)
// Configuration macro: RR_MUX_FIXED_PRIO_EN
//   defined   -> scan always starts at channel 0 (lowest index wins), no pointer
//   undefined -> round-robin, pointer advances past each accepted channel
module rr_mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic            clk,
    input  logic            reset,
    rr_mux_arbiter_if.slave bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             can_load;
    logic             any_valid;
    logic             accept;
    logic             found;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;

`ifndef RR_MUX_FIXED_PRIO_EN
    logic [SEL_W-1:0] ptr;
`endif

    assign any_valid = |bus.in_valid;

    // Winner selection. Round-robin is done as two priority scans: first the
    // channels at or above ptr, then (if none) the whole vector from 0, which
    // covers the wrapped part ptr-1..0 without any modulo arithmetic.
    always_comb begin
        grant = '0;
        found = 1'b0;
`ifdef RR_MUX_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (!found && bus.in_valid[i]) begin
                grant = SEL_W'(i);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && bus.in_valid[i] && (SEL_W'(i) >= ptr)) begin
                grant = SEL_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && bus.in_valid[i]) begin
                grant = SEL_W'(i);
                found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == grant) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage FSM, next-state half. reset gates accept so in_ready is
    // held low for the whole time reset is asserted.
    always_comb begin
        state_next = state;
        can_load   = (state == EMPTY) || bus.out_ready;
        accept     = any_valid && can_load && !reset;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (bus.out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        bus.in_ready = '0;
        if (accept) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
            out_sel_q  <= '0;
        end else if (accept) begin
            out_data_q <= grant_data;
            out_sel_q  <= grant;
        end
    end

`ifndef RR_MUX_FIXED_PRIO_EN
    // Explicit wrap at N-1 keeps ptr in range when N is not a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter (N=4 plus an N=3 instance)
module tb_rr_mux_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(W), .N(N)) bus ();
    rr_mux_arbiter_if #(.WIDTH(W), .N(3)) bus3 ();

    rr_mux_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_mux_arbiter #(.WIDTH(W), .N(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int total = 0;
    int bad = 0;
    beat_t q[$];
    int mptr = 0;
    logic [N-1:0] last_rdy;
    logic [1:0]   last_sel;
    logic [W-1:0] last_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_ch(input int i, input logic v, input logic [W-1:0] d);
        bus.in_valid[i] = v;
        bus.in_data[i*W +: W] = d;
    endtask

    // One clock of the N=4 instance: compare against the scoreboard at the
    // falling edge, update the model, then return just after the rising edge.
    task automatic cyc(input string tag);
        int g;
        logic cl;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        last_rdy  = bus.in_ready;
        last_sel  = bus.out_sel;
        last_data = bus.out_data;
        chk({tag, ".out_valid"}, bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk({tag, ".out_data"}, bus.out_data, q[0].data);
            chk({tag, ".out_sel"}, bus.out_sel, q[0].sel);
        end
        cl = (q.size() == 0) || bus.out_ready;
`ifdef RR_MUX_FIXED_PRIO_EN
        g = model_grant(bus.in_valid, 0);
`else
        g = model_grant(bus.in_valid, mptr);
`endif
        exp_rdy = (g >= 0 && cl) ? N'(1 << g) : '0;
        chk({tag, ".in_ready"}, bus.in_ready, exp_rdy);
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (g >= 0 && cl) begin
            q.push_back('{sel: 2'(g), data: bus.in_data[g*W +: W]});
            mptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rot_sel[5];
        int exp3_rdy[4];
        int exp3_sel[4];
        rot_sel  = '{0, 1, 2, 3, 0};
        exp3_rdy = '{1, 2, 4, 1};
        exp3_sel = '{0, 0, 1, 2};

        bus.out_ready  = 1'b0;
        bus3.out_ready = 1'b1;
        bus3.in_valid  = '0;
        for (int i = 0; i < 3; i++) bus3.in_data[i*W +: W] = 32'h200 + i;
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, 32'h100 + i);

        // Reset state with every channel requesting
        @(negedge clk);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out_data", bus.out_data, 0);
        chk("rst.out_sel", bus.out_sel, 0);
        chk("rst.in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef RR_MUX_FIXED_PRIO_EN
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc("fix_all");
            if (k > 0) chk("fix_all.sel0", last_sel, 0);
        end
        set_ch(0, 1'b0, 32'h100);
        cyc("fix_ch0_idle_flush");
        for (int k = 0; k < 3; k++) begin
            cyc("fix_ch0_idle");
            chk("fix_ch0_idle.sel1", last_sel, 1);
        end
`else
        // Rotation: 0,1,2,3,0 on consecutive cycles
        bus.out_ready = 1'b1;
        cyc("rot");
        chk("rot.first_grant_ch0", last_rdy, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            cyc("rot");
            chk("rot.sel_seq", last_sel, rot_sel[k]);
            chk("rot.data_seq", last_data, 32'h100 + rot_sel[k]);
        end

        // Backpressure while holding the ch1 beat
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc("bp");
            chk("bp.in_ready_zero", last_rdy, 0);
            chk("bp.data_hold", last_data, 32'h101);
            chk("bp.sel_hold", last_sel, 1);
        end
        bus.out_ready = 1'b1;
        cyc("bp_release");
        chk("bp_release.grant_ch2", last_rdy, 4'b0100);

        // Asynchronous reset in the middle of a held beat
        reset = 1'b1;
        #1;
        chk("async_rst.out_valid", bus.out_valid, 0);
        chk("async_rst.out_data", bus.out_data, 0);
        chk("async_rst.out_sel", bus.out_sel, 0);
        chk("async_rst.in_ready", bus.in_ready, 0);
        q.delete();
        mptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("post_rst");
        chk("post_rst.grant_ch0", last_rdy, 4'b0001);

        // Skip: pointer at 3, only ch1 requesting, then pointer must be 2
        cyc("skip_pre");
        cyc("skip_pre");
        for (int i = 0; i < N; i++) bus.in_valid[i] = (i == 1);
        cyc("skip");
        chk("skip.grant_ch1", last_rdy, 4'b0010);
        bus.in_valid = 4'b1010;
        cyc("skip_ptr2");
        chk("skip_ptr2.grant_ch3", last_rdy, 4'b1000);
        bus.in_valid = '0;
        cyc("drain");

        // Wrap at N-1 on the 3-channel instance
        bus3.in_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("n3.in_ready", bus3.in_ready, exp3_rdy[k]);
            if (k > 0) chk("n3.out_sel", bus3.out_sel, exp3_sel[k]);
            @(posedge clk);
            #1;
        end
        bus3.in_valid = '0;
`endif

        // Random traffic; a channel only changes data once taken or idle
        for (int n = 0; n < 300; n++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc("rand");
            for (int i = 0; i < N; i++) begin
                if (!bus.in_valid[i] || last_rdy[i]) begin
                    set_ch(i, ($urandom_range(0, 2) != 0), $urandom);
                end
            end
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        cyc("final_drain");
        cyc("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
